// File: rtl/ddr3_rd_pkg.sv
// ddr3_rd_pkg: state encoding, header field offsets and trailer layout shared by the fill reader.
package ddr3_rd_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_POP, ST_HDR_WAIT, ST_HDR_SEND,
    ST_BURST_REQ, ST_BURST_WAIT, ST_DATA_SEND, ST_TRL_SEND
  } rd_state_e;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_CNT_LSB  = 32;
  localparam int CNT_W        = 23;
  localparam logic [7:0] TRL_MARKER = 8'hFE;
  // Trailer word: {marker, bursts sent, timeout flag, 32 zero bits, checksum}
  function automatic logic [127:0] trailer(input logic [CNT_W-1:0] sent, input logic to,
                                           input logic [63:0] chk);
    return {TRL_MARKER, sent, to, 32'h0, chk};
  endfunction
endpackage

// File: rtl/fill_checksum_acc.sv
// fill_checksum_acc: 64-bit XOR-fold accumulator; nxt_o already includes the word being folded in.
module fill_checksum_acc (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [127:0] d_i,
  output logic [63:0]  nxt_o
);
  logic [63:0] acc_q;
  assign nxt_o = en_i ? acc_q ^ d_i[127:64] ^ d_i[63:0] : acc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_q <= '0;
    else acc_q <= clr_i ? '0 : nxt_o;
endmodule

// File: rtl/ddr3_fill_reader.sv
// ddr3_fill_reader: pops a fill header, fetches its bursts one at a time from DDR3
// and streams header, data and a checksum trailer to the readout link.
module ddr3_fill_reader
  import ddr3_rd_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 128,
  parameter int TO_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              readout_en,
  input  logic              fill_header_fifo_empty,
  output logic              fill_header_fifo_rd_en,
  input  logic [DATA_W-1:0] fill_header_fifo_out,
  output logic [ADDR_W-1:0] ddr3_rd_burst_addr,
  output logic              ddr3_rd_one_burst,
  input  logic              ddr3_one_burst_rdy,
  input  logic [DATA_W-1:0] ddr3_one_burst_data,
  output logic [DATA_W-1:0] rd_dat,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              rd_busy,
  output logic              rd_timeout_err,
  output logic [15:0]       fills_done
);
  localparam int TW = $clog2(TO_CYC + 1);
  rd_state_e         state_q, state_d;
  logic              rd_en_q, rd_en_d, one_q, one_d, valid_q, valid_d, last_q, last_d;
  logic              busy_q, to_q, to_d, err_q, err_d, chk_en, chk_clr;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  n_q, n_d, sent_q, sent_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [15:0]       fills_q, fills_d;
  logic [63:0]       chk_nxt;
  fill_checksum_acc u_chk (
    .clk(clk), .reset_n(reset_n), .clr_i(chk_clr), .en_i(chk_en), .d_i(dat_q), .nxt_o(chk_nxt)
  );
  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    one_d   = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;
    dat_d   = dat_q;
    addr_d  = addr_q;
    n_d     = n_q;
    sent_d  = sent_q;
    tmr_d   = tmr_q;
    to_d    = to_q;
    err_d   = err_q;
    fills_d = fills_q;
    chk_en  = 1'b0;
    chk_clr = 1'b0;
    case (state_q)
      ST_IDLE: if (readout_en && !fill_header_fifo_empty) begin
        rd_en_d = 1'b1;
        state_d = ST_POP;
      end
      ST_POP: state_d = ST_HDR_WAIT;
      ST_HDR_WAIT: begin
        addr_d  = fill_header_fifo_out[HDR_ADDR_LSB +: ADDR_W];
        n_d     = fill_header_fifo_out[HDR_CNT_LSB +: CNT_W];
        dat_d   = fill_header_fifo_out;
        valid_d = 1'b1;
        state_d = ST_HDR_SEND;
      end
      ST_HDR_SEND: if (rd_ready) begin
        valid_d = 1'b0;
        state_d = (n_q != '0) ? ST_BURST_REQ : ST_TRL_SEND;
      end
      ST_BURST_REQ: begin
        one_d   = 1'b1;
        tmr_d   = '0;
        state_d = ST_BURST_WAIT;
      end
      ST_BURST_WAIT: if (ddr3_one_burst_rdy) begin
        dat_d   = ddr3_one_burst_data;
        valid_d = 1'b1;
        state_d = ST_DATA_SEND;
      end else if (tmr_q == TW'(TO_CYC - 1)) begin
        err_d   = 1'b1;
        to_d    = 1'b1;
        state_d = ST_TRL_SEND;
      end else tmr_d = tmr_q + TW'(1);
      ST_DATA_SEND: if (rd_ready) begin
        chk_en  = 1'b1;
        sent_d  = sent_q + CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        valid_d = 1'b0;
        state_d = (sent_d != n_q) ? ST_BURST_REQ : ST_TRL_SEND;
      end
      ST_TRL_SEND: if (rd_ready) begin
        fills_d = fills_q + 16'd1;
        chk_clr = 1'b1;
        sent_d  = '0;
        to_d    = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Every route into the trailer builds it here so the final checksum includes the last burst
    if (state_d == ST_TRL_SEND && state_q != ST_TRL_SEND) begin
      dat_d   = trailer(sent_d, to_d, chk_nxt);
      valid_d = 1'b1;
      last_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      one_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      dat_q   <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      sent_q  <= '0;
      tmr_q   <= '0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      fills_q <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      one_q   <= one_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= state_d != ST_IDLE;
      dat_q   <= dat_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      sent_q  <= sent_d;
      tmr_q   <= tmr_d;
      to_q    <= to_d;
      err_q   <= err_d;
      fills_q <= fills_d;
    end
  assign fill_header_fifo_rd_en = rd_en_q;
  assign ddr3_rd_burst_addr     = addr_q;
  assign ddr3_rd_one_burst      = one_q;
  assign rd_dat                 = dat_q;
  assign rd_valid               = valid_q;
  assign rd_last                = last_q;
  assign rd_busy                = busy_q;
  assign rd_timeout_err         = err_q;
  assign fills_done             = fills_q;
endmodule
